// File: rtl/cirno_seq_pkg.sv
// rtl/cirno_seq_pkg.sv - shared types, phase-bit layout and default phase table for the cirno sequencer
package cirno_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SEL,
        S_OF,
        S_ALU,
        S_MEM,
        S_RS,
        S_HALTED,
        S_FAULT
    } seq_state_t;

    localparam int PH_OF    = 0;
    localparam int PH_ALU   = 1;
    localparam int PH_WM    = 2;
    localparam int PH_RM    = 3;
    localparam int PH_RS    = 4;
    localparam int PH_VALID = 5;
    localparam int PHASE_W  = 6;

    // Index = instruction type; bits {VALID, RS, RM, WM, ALU, OF}.
    localparam logic [PHASE_W-1:0] DEFAULT_PHASE_MAP [8] = '{
        6'b000000,  // 0: invalid
        6'b110011,  // 1: OF ALU RS
        6'b100000,  // 2: no phases
        6'b110000,  // 3: RS
        6'b100001,  // 4: OF
        6'b100101,  // 5: OF WM
        6'b111001,  // 6: OF RM RS
        6'b000000   // 7: invalid
    };

    // First enabled phase strictly after cur in the fixed order OF, ALU, MEM, RS.
    function automatic seq_state_t next_phase(input logic [PHASE_W-1:0] mask,
                                              input seq_state_t cur);
        logic after_sel;
        logic after_of;
        logic after_alu;
        logic after_mem;
        after_sel = (cur == S_SEL);
        after_of  = after_sel || (cur == S_OF);
        after_alu = after_of  || (cur == S_ALU);
        after_mem = after_alu || (cur == S_MEM);
        if (after_sel && mask[PH_OF])                   return S_OF;
        if (after_of  && mask[PH_ALU])                  return S_ALU;
        if (after_alu && (mask[PH_WM] || mask[PH_RM]))  return S_MEM;
        if (after_mem && mask[PH_RS])                   return S_RS;
        return S_FETCH;
    endfunction

endpackage

// File: rtl/cirno_seq_timeout.sv
// rtl/cirno_seq_timeout.sv - memory-wait counter with clear, enable and expired flag
module cirno_seq_timeout #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic init_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry fires on the wait cycle that would bring the count to MEM_TIMEOUT.
    assign expired_o = (MEM_TIMEOUT != 0) && en_i && (cnt_q == CW'(MEM_TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cirno_sequencer.sv
// rtl/cirno_sequencer.sv - table-driven multicycle control sequencer for the cirno core
module cirno_sequencer
    import cirno_seq_pkg::*;
#(
    parameter int NUM_TYPES = 8,
    parameter logic [PHASE_W-1:0] PHASE_MAP [NUM_TYPES] = cirno_seq_pkg::DEFAULT_PHASE_MAP,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W = 16,
    localparam int TYPE_W = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic              start,
    input  logic [TYPE_W-1:0] inst_type,
    input  logic              halt_req,
    input  logic              mem_ready,
    output logic              fetch_en,
    output logic              decode_en,
    output logic              opfetch_en,
    output logic              alu_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              reg_w_en,
    output logic              reg_mem_w_en,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [CNT_W-1:0]  retired
);

    seq_state_t         state_q, state_d;
    logic [PHASE_W-1:0] cur_mask_q, cur_mask_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [PHASE_W-1:0] sel_mask;
    logic               retire;
    logic               in_mem;
    logic               tmo_expired;

    // Types at or beyond NUM_TYPES match no entry and read as invalid.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NUM_TYPES; i++) begin
            if (inst_type == TYPE_W'(i)) begin
                sel_mask = PHASE_MAP[i];
            end
        end
    end

    assign in_mem = (state_q == S_MEM);

    cirno_seq_timeout #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .init_n    (init_n),
        .clr_i     (!in_mem),
        .en_i      (in_mem && !mem_ready),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        cur_mask_d = cur_mask_q;
        retire     = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALTED, S_FAULT: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_SEL;
            S_SEL: begin
                cur_mask_d = sel_mask;
                if (halt_req) begin
                    state_d = S_HALTED;
                end else if (!sel_mask[PH_VALID] || (sel_mask[PH_WM] && sel_mask[PH_RM])) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = next_phase(sel_mask, S_SEL);
                    retire  = (state_d == S_FETCH);
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = next_phase(cur_mask_q, S_MEM);
                    retire  = (state_d == S_FETCH);
                end else if (tmo_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_OF, S_ALU, S_RS: begin
                state_d = next_phase(cur_mask_q, state_q);
                retire  = (state_d == S_FETCH);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q    <= S_IDLE;
            cur_mask_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_mask_q <= cur_mask_d;
            retired_q  <= retired_d;
        end
    end

    // Outputs decode only registered state, so they go low the moment reset hits.
    assign fetch_en     = (state_q == S_FETCH);
    assign decode_en    = (state_q == S_DECODE);
    assign opfetch_en   = (state_q == S_OF);
    assign alu_en       = (state_q == S_ALU);
    assign mem_r_en     = in_mem && cur_mask_q[PH_RM];
    assign mem_w_en     = in_mem && cur_mask_q[PH_WM];
    assign reg_w_en     = (state_q == S_RS) && !cur_mask_q[PH_RM];
    assign reg_mem_w_en = (state_q == S_RS) && cur_mask_q[PH_RM];
    assign busy         = !((state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_FAULT));
    assign done         = (state_q == S_HALTED) || (state_q == S_FAULT);
    assign fault        = (state_q == S_FAULT);
    assign retired      = retired_q;

endmodule

// File: tb/tb_cirno_sequencer.sv
// tb/tb_cirno_sequencer.sv - directed self-checking bench for cirno_sequencer
module tb_cirno_sequencer;

    localparam logic [10:0] E_FETCH = 11'h400;
    localparam logic [10:0] E_DEC   = 11'h200;
    localparam logic [10:0] E_OF    = 11'h100;
    localparam logic [10:0] E_ALU   = 11'h080;
    localparam logic [10:0] E_MR    = 11'h040;
    localparam logic [10:0] E_MW    = 11'h020;
    localparam logic [10:0] E_RW    = 11'h010;
    localparam logic [10:0] E_RMW   = 11'h008;
    localparam logic [10:0] E_BUSY  = 11'h004;
    localparam logic [10:0] E_DONE  = 11'h002;
    localparam logic [10:0] E_FAULT = 11'h001;

    logic       clk;
    logic       init_n;
    logic       start;
    logic [2:0] inst_type;
    logic       halt_req;
    logic       mem_ready;

    logic a_fetch, a_dec, a_of, a_alu, a_mr, a_mw, a_rw, a_rmw, a_busy, a_done, a_fault;
    logic b_fetch, b_dec, b_of, b_alu, b_mr, b_mw, b_rw, b_rmw, b_busy, b_done, b_fault;
    logic [15:0] a_retired;
    logic [1:0]  b_retired;
    logic [10:0] vec_a, vec_b;

    int n_chk;
    int n_fail;

    cirno_sequencer dut_a (
        .clk(clk), .init_n(init_n), .start(start), .inst_type(inst_type),
        .halt_req(halt_req), .mem_ready(mem_ready),
        .fetch_en(a_fetch), .decode_en(a_dec), .opfetch_en(a_of), .alu_en(a_alu),
        .mem_r_en(a_mr), .mem_w_en(a_mw), .reg_w_en(a_rw), .reg_mem_w_en(a_rmw),
        .busy(a_busy), .done(a_done), .fault(a_fault), .retired(a_retired)
    );

    cirno_sequencer #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_b (
        .clk(clk), .init_n(init_n), .start(start), .inst_type(inst_type),
        .halt_req(halt_req), .mem_ready(mem_ready),
        .fetch_en(b_fetch), .decode_en(b_dec), .opfetch_en(b_of), .alu_en(b_alu),
        .mem_r_en(b_mr), .mem_w_en(b_mw), .reg_w_en(b_rw), .reg_mem_w_en(b_rmw),
        .busy(b_busy), .done(b_done), .fault(b_fault), .retired(b_retired)
    );

    assign vec_a = {a_fetch, a_dec, a_of, a_alu, a_mr, a_mw, a_rw, a_rmw, a_busy, a_done, a_fault};
    assign vec_b = {b_fetch, b_dec, b_of, b_alu, b_mr, b_mw, b_rw, b_rmw, b_busy, b_done, b_fault};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input bit use_b, input logic [10:0] exp);
        @(posedge clk);
        #1;
        check(tag, use_b ? {21'd0, vec_b} : {21'd0, vec_a}, {21'd0, exp});
    endtask

    task automatic do_reset();
        init_n    = 1'b0;
        start     = 1'b0;
        halt_req  = 1'b0;
        mem_ready = 1'b0;
        inst_type = 3'd0;
        @(posedge clk);
        #1;
        init_n = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_r [5];
        n_chk  = 0;
        n_fail = 0;
        exp_r  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Held reset
        init_n = 1'b0; start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0; inst_type = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_out_a", {21'd0, vec_a}, 32'd0);
        check("rst_out_b", {21'd0, vec_b}, 32'd0);
        check("rst_ret", {16'd0, a_retired}, 32'd0);
        init_n = 1'b1;
        cyc("idle_hold", 0, 11'd0);

        // Type 1 with start held high throughout
        start = 1'b1; inst_type = 3'd1;
        cyc("t1_fetch", 0, E_FETCH | E_BUSY);
        cyc("t1_dec",   0, E_DEC | E_BUSY);
        cyc("t1_sel",   0, E_BUSY);
        cyc("t1_of",    0, E_OF | E_BUSY);
        cyc("t1_alu",   0, E_ALU | E_BUSY);
        cyc("t1_rs",    0, E_RW | E_BUSY);
        check("t1_ret_pre", {16'd0, a_retired}, 32'd0);
        cyc("t1_fetch2", 0, E_FETCH | E_BUSY);
        check("t1_ret", {16'd0, a_retired}, 32'd1);
        cyc("t1_dec2",  0, E_DEC | E_BUSY);
        cyc("t1_sel2",  0, E_BUSY);
        cyc("t1_of2",   0, E_OF | E_BUSY);
        cyc("t1_alu2",  0, E_ALU | E_BUSY);
        // Asynchronous reset in the middle of ALU
        init_n = 1'b0;
        #1;
        check("rst_mid_alu", {21'd0, vec_a}, 32'd0);
        check("rst_mid_ret", {16'd0, a_retired}, 32'd0);
        @(posedge clk); #1;
        start  = 1'b0;
        init_n = 1'b1;
        cyc("rst_mid_idle", 0, 11'd0);

        // Type 6 with three wait cycles
        do_reset();
        start = 1'b1; inst_type = 3'd6;
        cyc("t6_fetch", 0, E_FETCH | E_BUSY);
        start = 1'b0;
        cyc("t6_dec", 0, E_DEC | E_BUSY);
        cyc("t6_sel", 0, E_BUSY);
        cyc("t6_of",  0, E_OF | E_BUSY);
        for (int i = 0; i < 4; i++) cyc($sformatf("t6_mem%0d", i), 0, E_MR | E_BUSY);
        mem_ready = 1'b1;
        cyc("t6_rs", 0, E_RMW | E_BUSY);
        mem_ready = 1'b0;
        cyc("t6_fetch2", 0, E_FETCH | E_BUSY);
        check("t6_ret", {16'd0, a_retired}, 32'd1);

        // Type 5 memory timeout on the MEM_TIMEOUT=4 instance
        do_reset();
        start = 1'b1; inst_type = 3'd5;
        cyc("tmo_fetch", 1, E_FETCH | E_BUSY);
        start = 1'b0;
        cyc("tmo_dec", 1, E_DEC | E_BUSY);
        cyc("tmo_sel", 1, E_BUSY);
        cyc("tmo_of",  1, E_OF | E_BUSY);
        for (int i = 0; i < 4; i++) cyc($sformatf("tmo_mem%0d", i), 1, E_MW | E_BUSY);
        cyc("tmo_fault", 1, E_DONE | E_FAULT);
        check("tmo_ret", {30'd0, b_retired}, 32'd0);
        cyc("tmo_hold", 1, E_DONE | E_FAULT);
        start = 1'b1;
        cyc("tmo_restart", 1, E_FETCH | E_BUSY);

        // Halt request in SEL
        do_reset();
        start = 1'b1; inst_type = 3'd1; halt_req = 1'b1;
        cyc("halt_fetch", 0, E_FETCH | E_BUSY);
        start = 1'b0;
        cyc("halt_dec", 0, E_DEC | E_BUSY);
        cyc("halt_sel", 0, E_BUSY);
        cyc("halt_st",  0, E_DONE);
        cyc("halt_hold", 0, E_DONE);
        halt_req = 1'b0;
        check("halt_ret", {16'd0, a_retired}, 32'd0);

        // Invalid types 0 and 7
        do_reset();
        start = 1'b1; inst_type = 3'd0;
        cyc("ill0_fetch", 0, E_FETCH | E_BUSY);
        start = 1'b0;
        cyc("ill0_dec", 0, E_DEC | E_BUSY);
        cyc("ill0_sel", 0, E_BUSY);
        cyc("ill0_fault", 0, E_DONE | E_FAULT);
        start = 1'b1; inst_type = 3'd7;
        cyc("ill7_fetch", 0, E_FETCH | E_BUSY);
        start = 1'b0;
        cyc("ill7_dec", 0, E_DEC | E_BUSY);
        cyc("ill7_sel", 0, E_BUSY);
        cyc("ill7_fault", 0, E_DONE | E_FAULT);
        check("ill_ret", {16'd0, a_retired}, 32'd0);

        // Retired counter wrap with CNT_W=2
        do_reset();
        start = 1'b1; inst_type = 3'd2;
        cyc("wrap_fetch", 1, E_FETCH | E_BUSY);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc($sformatf("wrap_dec%0d", k), 1, E_DEC | E_BUSY);
            cyc($sformatf("wrap_sel%0d", k), 1, E_BUSY);
            cyc($sformatf("wrap_fetch%0d", k), 1, E_FETCH | E_BUSY);
            check($sformatf("wrap_ret%0d", k), {30'd0, b_retired}, {30'd0, exp_r[k]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cirno_sequencer.md
# cirno_sequencer

Parametrised multicycle control sequencer for the cirno core, driving fetch, decode, operand-fetch, ALU, memory and register-writeback enables one phase at a time.
- Per-instruction-type phase sequences come from a table parameter instead of hard-coded cases.
- Memory phases use a ready handshake with a timeout.
- Halt and illegal-type faults are explicit states, and retired instructions are counted.
- Sits between `decoder` (which supplies `inst_type` and `halt_req`) and the datapath blocks `fetch_unit`, `register`, `alu` and `memory`.

## Interface
Parameters:
- `NUM_TYPES`, default 8: number of instruction types. `TYPE_W = $clog2(NUM_TYPES)` is a localparam.
- `PHASE_MAP`, default `cirno_seq_pkg::DEFAULT_PHASE_MAP`: array of `NUM_TYPES` entries, each 6 bits wide.
  - Bit 0 OF, bit 1 ALU, bit 2 WM, bit 3 RM, bit 4 RS, bit 5 VALID.
- `MEM_TIMEOUT`, default 15: number of memory-wait cycles before a fault. 0 disables the timeout.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `init_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled run request; accepted only in IDLE, HALTED or FAULT.
- `inst_type`  in  TYPE_W  decoded type; valid in the SEL cycle.
- `halt_req`  in  1  decoder flags a halt instruction; sampled in SEL.
- `mem_ready`  in  1  memory has completed the current read or write.
- `fetch_en`, `decode_en`, `opfetch_en`, `alu_en`  out  1 each  phase enables.
- `mem_r_en`, `mem_w_en`  out  1 each  memory phase enables.
- `reg_w_en`, `reg_mem_w_en`  out  1 each  writeback enables.
- `busy`  out  1  high in any state other than IDLE, HALTED or FAULT.
- `done`  out  1  high in HALTED and FAULT.
- `fault`  out  1  high in FAULT.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
States: IDLE, FETCH, DECODE, SEL, OF, ALU, MEM, RS, HALTED, FAULT.

Transitions:
- IDLE: `start` -> FETCH.
- FETCH -> DECODE -> SEL. FETCH and DECODE each last exactly one cycle.
- SEL priority, highest first:
  1. `halt_req` -> HALTED.
  2. Entry VALID=0, or WM and RM both set -> FAULT.
  3. Otherwise -> first set phase in order OF, ALU, MEM (WM or RM), RS.
  4. If no phase bit is set -> FETCH, and the instruction retires.
- SEL latches the mask into `cur_mask`. Each later phase advances to the next set phase in the same order. Leaving the last phase goes to FETCH and retires the instruction.
- MEM:
  - `mem_w_en` (WM) or `mem_r_en` (RM) is held high for the whole time in MEM.
  - Exit on the first cycle `mem_ready` is sampled high.
  - A wait counter increments each cycle `mem_ready` is low. When it reaches `MEM_TIMEOUT` (nonzero) -> FAULT.
  - The counter clears on MEM entry.
- RS: asserts `reg_mem_w_en` if `cur_mask` has RM set, otherwise `reg_w_en`.
- HALTED and FAULT: `start` -> FETCH, clearing `done` and `fault`. Otherwise the state holds.

Counter and boundary rules:
- `retired` increments by 1 on each retire and wraps modulo 2^CNT_W. It is cleared only by reset.
- Halt and fault do not increment `retired`.
- `start` while `busy` is ignored.
- `mem_ready` outside MEM is ignored.
- `inst_type` values at or above `NUM_TYPES` are treated as VALID=0.

## Timing
- Every output is a registered state decode. Each phase enable is high exactly for the cycles the FSM is in that state.
- Reset: state IDLE. All enables, `busy`, `done` and `fault` are 0; `retired` is 0. Reset takes effect immediately, including mid-phase, and leaves no partial pulse after `init_n` is deasserted.
- Cycles per instruction, FETCH to next FETCH:
  - 3 + number of set phases.
  - MEM counts as 1 + wait cycles.
- Default types:
  - type 2 (no phases): 3 cycles.
  - type 1 (OF, ALU, RS): 6 cycles.
  - type 6 (OF, RM, RS) with zero-wait memory: 6 cycles.
- `start` high in IDLE at edge n gives `fetch_en` high in cycle n+1.

## Structure
- `cirno_seq_pkg` contains:
  - the state enum `seq_state_t`;
  - the phase bit index constants `PH_OF`, `PH_ALU`, `PH_WM`, `PH_RM`, `PH_RS`, `PH_VALID`;
  - `DEFAULT_PHASE_MAP`: type 0 invalid; 1 = OF|ALU|RS; 2 = none; 3 = RS; 4 = OF; 5 = OF|WM; 6 = OF|RM|RS; 7 invalid. Every valid entry has VALID set.
- One sub-module, `cirno_seq_timeout`: a wait counter with clear, enable and an expired flag, parametrised by `MEM_TIMEOUT`.
- The next-phase selection is a function in `cirno_seq_pkg`.

## Test plan
- Reset: hold `init_n`=0 -> all outputs 0 and `retired`=0. Assert `init_n`=0 during ALU -> all enables 0 in the same cycle, state IDLE.
- Type 1 (OF, ALU, RS): `start`, `inst_type`=1 -> `fetch_en`, `decode_en`, (SEL), `opfetch_en`, `alu_en`, `reg_w_en` on successive cycles; `retired`=1; `fetch_en` again in cycle 7.
- Type 6 (OF, RM, RS) with `mem_ready` low for 3 cycles -> `mem_r_en` high 4 cycles, then `reg_mem_w_en` for 1 cycle, `reg_w_en` never asserted.
- `MEM_TIMEOUT`=4, type 5, `mem_ready` held 0 -> `mem_w_en` high 4 cycles, then `fault`=1, `done`=1, `retired` unchanged. `start` -> FETCH, `fault`=0.
- `halt_req`=1 in SEL -> HALTED, `done`=1, no phase enables. `start` held during a running instruction -> ignored.
- `inst_type`=0 and `inst_type`=7 -> FAULT. `CNT_W`=2 with 5 type-2 instructions -> `retired` sequence 1, 2, 3, 0, 1.
